// File: rtl/midi_byte_parser.sv
// MIDI byte-stream framer: running status, message length, real-time split.
// Optional active-sensing watchdog enabled by defining MIDI_ACTIVE_SENSE_EN.
module midi_byte_parser #(
  parameter int unsigned CLK_HZ           = 50000000,
  parameter int unsigned SENSE_TIMEOUT_MS = 300
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_in_data,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic [7:0] drop_cnt,
  output logic       sense_lost
);

  localparam logic [31:0] SENSE_CYCLES = 32'(CLK_HZ / 1000 * SENSE_TIMEOUT_MS);

  typedef enum logic [1:0] {ST_IDLE, ST_MSG, ST_SYSEX} state_t;

  state_t     state_q, state_d;
  logic [7:0] data_cnt_q, data_cnt_d;
  logic [1:0] exp_len_q, exp_len_d;
  logic [7:0] cnt_inc;
  logic [7:0] cur_status_d, midibyte_nr_d, midi_in_data_d, rt_byte_d, drop_cnt_d;
  logic       byteready_d, rt_valid_d;
  logic       is_rt;
  logic       sense_expire;

  // Data bytes that follow each status; SysEx is handled by its own state.
  function automatic logic [1:0] status_len(input logic [7:0] s);
    logic [1:0] len;
    len = 2'd0;
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (s[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

  assign is_rt   = (rx_byte[7:3] == 5'b11111);
  assign cnt_inc = (data_cnt_q == 8'hFF) ? 8'hFF : data_cnt_q + 8'd1;

`ifdef MIDI_ACTIVE_SENSE_EN
  logic        sense_armed;
  logic [31:0] sense_timer;

  assign sense_expire = sense_armed && !rx_valid && (sense_timer <= 32'd1);

  // Watchdog armed by the first FE; any received byte restarts the countdown.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sense_armed <= 1'b0;
      sense_timer <= 32'd0;
      sense_lost  <= 1'b0;
    end else begin
      sense_lost <= sense_expire;
      if (rx_valid) begin
        if (rx_byte == 8'hFE) sense_armed <= 1'b1;
        sense_timer <= SENSE_CYCLES;
      end else if (sense_armed) begin
        if (sense_timer <= 32'd1) sense_armed <= 1'b0;
        else sense_timer <= sense_timer - 32'd1;
      end
    end
  end
`else
  logic unused_sense_cfg;
  assign unused_sense_cfg = ^SENSE_CYCLES;
  assign sense_expire     = 1'b0;
  assign sense_lost       = 1'b0;
`endif

  // Once the parser drops to IDLE the visible status decays to 00 a cycle later.
  always_comb begin
    state_d        = state_q;
    cur_status_d   = (state_q == ST_IDLE) ? 8'h00 : cur_status;
    data_cnt_d     = data_cnt_q;
    exp_len_d      = exp_len_q;
    byteready_d    = 1'b0;
    rt_valid_d     = 1'b0;
    midibyte_nr_d  = midibyte_nr;
    midi_in_data_d = midi_in_data;
    rt_byte_d      = rt_byte;
    drop_cnt_d     = drop_cnt;

    if (sense_expire) begin
      state_d      = ST_IDLE;
      cur_status_d = 8'h00;
      data_cnt_d   = 8'd0;
    end else if (rx_valid) begin
      if (is_rt) begin
        rt_valid_d = 1'b1;
        rt_byte_d  = rx_byte;
      end else if (rx_byte[7]) begin
        cur_status_d   = rx_byte;
        midi_in_data_d = rx_byte;
        midibyte_nr_d  = 8'd0;
        byteready_d    = 1'b1;
        data_cnt_d     = 8'd0;
        exp_len_d      = status_len(rx_byte);
        if (rx_byte == 8'hF0)                                state_d = ST_SYSEX;
        else if (rx_byte[7:4] != 4'hF || status_len(rx_byte) != 2'd0) state_d = ST_MSG;
        else                                                 state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        if (drop_cnt != 8'hFF) drop_cnt_d = drop_cnt + 8'd1;
      end else begin
        byteready_d    = 1'b1;
        midi_in_data_d = rx_byte;
        midibyte_nr_d  = cnt_inc;
        if (state_q == ST_SYSEX) begin
          data_cnt_d = cnt_inc;
        end else if (cnt_inc == {6'd0, exp_len_q}) begin
          // System-common messages cancel running status once complete.
          data_cnt_d = 8'd0;
          if (cur_status[7:4] == 4'hF) state_d = ST_IDLE;
        end else begin
          data_cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= ST_IDLE;
      data_cnt_q   <= 8'd0;
      exp_len_q    <= 2'd0;
      cur_status   <= 8'h00;
      byteready    <= 1'b0;
      midibyte_nr  <= 8'd0;
      midi_in_data <= 8'd0;
      rt_valid     <= 1'b0;
      rt_byte      <= 8'd0;
      drop_cnt     <= 8'd0;
    end else begin
      state_q      <= state_d;
      data_cnt_q   <= data_cnt_d;
      exp_len_q    <= exp_len_d;
      cur_status   <= cur_status_d;
      byteready    <= byteready_d;
      midibyte_nr  <= midibyte_nr_d;
      midi_in_data <= midi_in_data_d;
      rt_valid     <= rt_valid_d;
      rt_byte      <= rt_byte_d;
      drop_cnt     <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Scoreboard bench for midi_byte_parser; the watchdog test runs only when
// MIDI_ACTIVE_SENSE_EN is defined.
module tb_midi_byte_parser;

  logic       reg_clk = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       byteready, rt_valid, sense_lost;
  logic [7:0] cur_status, midibyte_nr, midi_in_data, rt_byte, drop_cnt;

  int checks = 0;
  int failures = 0;

  // {byteready, rt_valid, cur_status, midibyte_nr, data-or-rt_byte}
  typedef logic [25:0] exp_t;
  exp_t sb[$];

  midi_byte_parser #(.CLK_HZ(1000), .SENSE_TIMEOUT_MS(3)) dut (
    .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .byteready(byteready), .cur_status(cur_status), .midibyte_nr(midibyte_nr),
    .midi_in_data(midi_in_data), .rt_valid(rt_valid), .rt_byte(rt_byte),
    .drop_cnt(drop_cnt), .sense_lost(sense_lost)
  );

  always #5 reg_clk = ~reg_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation hung");
  end

  function automatic exp_t ev_br(input logic [7:0] st, input logic [7:0] nr, input logic [7:0] d);
    return {1'b1, 1'b0, st, nr, d};
  endfunction

  function automatic exp_t ev_rt(input logic [7:0] st, input logic [7:0] b);
    return {1'b0, 1'b1, st, 8'h00, b};
  endfunction

  function automatic exp_t ev_none(input logic [7:0] st);
    return {1'b0, 1'b0, st, 16'h0000};
  endfunction

  function automatic exp_t observe();
    return {byteready, rt_valid, cur_status,
            byteready ? midibyte_nr : 8'h00,
            byteready ? midi_in_data : (rt_valid ? rt_byte : 8'h00)};
  endfunction

  task automatic send(input logic [7:0] b, input exp_t e);
    @(negedge reg_clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_reg_N = 1'b0;
    rx_valid    = 1'b1;
    rx_byte     = 8'h90;
    repeat (2) @(negedge reg_clk);
    checks++;
    if ({byteready, rt_valid, sense_lost} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_strobes got=%b exp=000", {byteready, rt_valid, sense_lost});
    end
    checks++;
    if ({cur_status, midibyte_nr, midi_in_data, rt_byte, drop_cnt} !== 40'h0) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h exp=0", {cur_status, midibyte_nr, midi_in_data, rt_byte, drop_cnt});
    end
    rx_valid    = 1'b0;
    reset_reg_N = 1'b1;
    @(negedge reg_clk);
    checks++;
    if (cur_status !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_ignores_rx got=%h exp=00", cur_status);
    end
  endtask

  task automatic test_orphan();
    logic [7:0] stim [5] = '{8'h3C, 8'h40, 8'hC5, 8'h10, 8'h11};
    exp_t want [5];
    exp_t got, e;
    want = '{ev_none(8'h00), ev_none(8'h00), ev_br(8'hC5, 8'd0, 8'hC5),
             ev_br(8'hC5, 8'd1, 8'h10), ev_br(8'hC5, 8'd1, 8'h11)};
    for (int i = 0; i < 5; i++) begin
      send(stim[i], want[i]);
      @(negedge reg_clk);
      rx_valid = 1'b0;
      got = observe();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL orphan[%0d] got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if (drop_cnt !== 8'd2) begin
      failures++;
      $display("[TB] FAIL orphan_drop_cnt got=%0d exp=2", drop_cnt);
    end
  endtask

  task automatic test_running_status();
    logic [7:0] stim [5] = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00};
    exp_t want [5];
    exp_t got, e;
    want = '{ev_br(8'h90, 8'd0, 8'h90), ev_br(8'h90, 8'd1, 8'h3C), ev_br(8'h90, 8'd2, 8'h64),
             ev_br(8'h90, 8'd1, 8'h3C), ev_br(8'h90, 8'd2, 8'h00)};
    for (int i = 0; i < 5; i++) begin
      send(stim[i], want[i]);
      @(negedge reg_clk);
      rx_valid = 1'b0;
      got = observe();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL running_status[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_realtime();
    logic [7:0] stim [7] = '{8'h91, 8'h40, 8'hF8, 8'h7F, 8'hFD, 8'hF4, 8'h10};
    exp_t want [7];
    exp_t got, e;
    want = '{ev_br(8'h91, 8'd0, 8'h91), ev_br(8'h91, 8'd1, 8'h40), ev_rt(8'h91, 8'hF8),
             ev_br(8'h91, 8'd2, 8'h7F), ev_rt(8'h91, 8'hFD), ev_br(8'hF4, 8'd0, 8'hF4),
             ev_none(8'h00)};
    for (int i = 0; i < 7; i++) begin
      send(stim[i], want[i]);
      @(negedge reg_clk);
      rx_valid = 1'b0;
      got = observe();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL realtime[%0d] got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if (drop_cnt !== 8'd3) begin
      failures++;
      $display("[TB] FAIL realtime_drop_cnt got=%0d exp=3", drop_cnt);
    end
  endtask

  task automatic test_sysex();
    logic [7:0] stim[$];
    exp_t want[$];
    exp_t got, e;
    logic [7:0] d;
    stim.push_back(8'hF0);
    want.push_back(ev_br(8'hF0, 8'd0, 8'hF0));
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        stim.push_back(8'hF8);
        want.push_back(ev_rt(8'hF0, 8'hF8));
      end
      d = (i == 0) ? 8'h7E : (i == 1) ? 8'h00 : 8'(i % 128);
      stim.push_back(d);
      want.push_back(ev_br(8'hF0, (i < 255) ? 8'(i + 1) : 8'hFF, d));
    end
    stim.push_back(8'hF7);
    want.push_back(ev_br(8'hF7, 8'd0, 8'hF7));
    stim.push_back(8'h05);
    want.push_back(ev_none(8'h00));
    for (int i = 0; i < stim.size(); i++) begin
      send(stim[i], want[i]);
      @(negedge reg_clk);
      rx_valid = 1'b0;
      got = observe();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL sysex[%0d] got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if (drop_cnt !== 8'd4) begin
      failures++;
      $display("[TB] FAIL sysex_drop_cnt got=%0d exp=4", drop_cnt);
    end
  endtask

  task automatic test_drop_saturate();
    int br_seen = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge reg_clk);
      if (byteready) br_seen++;
      rx_valid = 1'b1;
      rx_byte  = 8'h22;
    end
    @(negedge reg_clk);
    rx_valid = 1'b0;
    @(negedge reg_clk);
    checks++;
    if (br_seen != 0) begin
      failures++;
      $display("[TB] FAIL drop_no_byteready got=%0d exp=0", br_seen);
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL drop_saturate got=%0d exp=255", drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stim [3] = '{8'h80, 8'h3C, 8'h40};
    exp_t want [3];
    exp_t got, e;
    logic pending;
    want = '{ev_br(8'h80, 8'd0, 8'h80), ev_br(8'h80, 8'd1, 8'h3C), ev_br(8'h80, 8'd2, 8'h40)};
    for (int i = 0; i < 4; i++) begin
      @(negedge reg_clk);
      if (i > 0) begin
        got = observe();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("[TB] FAIL back_to_back[%0d] got=%h exp=%h", i - 1, got, e);
        end
      end
      if (i < 3) begin
        rx_valid = 1'b1;
        rx_byte  = stim[i];
        sb.push_back(want[i]);
      end else begin
        rx_valid = 1'b0;
      end
    end
    // Reset lands while the strobe for 3C is being presented.
    @(negedge reg_clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h90;
    @(negedge reg_clk);
    rx_byte  = 8'h3C;
    @(posedge reg_clk);
    #2;
    pending = byteready;
    reset_reg_N = 1'b0;
    #1;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_pending got=%b exp=1", pending);
    end
    checks++;
    if ({byteready, rt_valid, cur_status, midibyte_nr, midi_in_data, drop_cnt} !== 34'h0) begin
      failures++;
      $display("[TB] FAIL midreset_clear got=%h exp=0",
               {byteready, rt_valid, cur_status, midibyte_nr, midi_in_data, drop_cnt});
    end
    @(negedge reg_clk);
    rx_valid    = 1'b0;
    reset_reg_N = 1'b1;
    send(8'h3C, ev_none(8'h00));
    @(negedge reg_clk);
    rx_valid = 1'b0;
    got = observe();
    e = sb.pop_front();
    checks++;
    if (got !== e || drop_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL postreset_drop got=%h/%0d exp=%h/1", got, drop_cnt, e);
    end
  endtask

  task automatic test_sense();
    exp_t got, e;
    send(8'h90, ev_br(8'h90, 8'd0, 8'h90));
    @(negedge reg_clk);
    rx_valid = 1'b0;
    got = observe();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL sense_status got=%h exp=%h", got, e);
    end
    send(8'hFE, ev_rt(8'h90, 8'hFE));
    @(negedge reg_clk);
    rx_valid = 1'b0;
    got = observe();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL sense_fe got=%h exp=%h", got, e);
    end
    for (int j = 1; j <= 5; j++) begin
      @(negedge reg_clk);
`ifdef MIDI_ACTIVE_SENSE_EN
      checks++;
      if (sense_lost !== (j == 3)) begin
        failures++;
        $display("[TB] FAIL sense_pulse[%0d] got=%b exp=%b", j, sense_lost, (j == 3));
      end
      checks++;
      if (cur_status !== ((j >= 3) ? 8'h00 : 8'h90)) begin
        failures++;
        $display("[TB] FAIL sense_status_clear[%0d] got=%h exp=%h", j, cur_status,
                 (j >= 3) ? 8'h00 : 8'h90);
      end
`else
      checks++;
      if (sense_lost !== 1'b0 || cur_status !== 8'h90) begin
        failures++;
        $display("[TB] FAIL sense_disabled[%0d] got=%b/%h exp=0/90", j, sense_lost, cur_status);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_orphan();
    test_running_status();
    test_realtime();
    test_sysex();
    test_drop_saturate();
    test_back_to_back();
    test_sense();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
